alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer: drives one 1-bit ALU slice (ALU_1bit) LSB-first for WIDTH cycles and assembles the WIDTH-bit result.
- The slice carry is held in a flop between bit cycles.
- Area-reduced alternative to the ripple ALU, for multi-cycle/EX-stall use in the pipeline.
- Start/Busy/Done handshake toward the issuing stage.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Start  input  1  request; accepted only in IDLE
- Sel  input  2  00 AND, 01 OR, 10/11 add/sub (slice encoding)
- InvertB  input  1  invert B and set initial carry-in = 1 (subtract)
- DataA  input  WIDTH  operand A
- DataB  input  WIDTH  operand B
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse when result is valid
- DataOut  output  WIDTH  result; held until next accepted Start
- Cout  output  1  carry out of MSB (add/sub); 0 for AND/OR
- Zero  output  1  DataOut == 0
- Overflow  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - State to IDLE.
  - Busy, Done, Cout, Zero, Overflow, DataOut, bit counter and carry flop all clear to 0.
  - Zero resets to 0 despite DataOut=0.
  - Takes priority over everything, including mid-RUN: the operation is aborted and no Done is issued.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - Start=1 at edge k: latch DataA, DataB, Sel, InvertB.
  - Carry flop <= InvertB; counter <= 0; go to RUN.
  - Busy=1 from cycle k+1.
- RUN (WIDTH cycles):
  - Each cycle, feed bit[counter] of A and B to the slice with Cin = carry flop.
  - Shift the slice DataOut into the result register from the MSB side; carry flop <= slice Cout.
  - On counter == WIDTH-1: capture final Cout and MSB carry-in, then go to FINISH. Otherwise counter++.
- FINISH (single cycle = cycle k+WIDTH+1):
  - Done=1, Busy=0.
  - DataOut, Cout, Zero, Overflow updated and valid this cycle.
  - Next state IDLE.
- Latency: Start edge to Done = WIDTH+1 cycles. Throughput: one op per WIDTH+2 cycles.
- Start while Busy or in FINISH: ignored, not queued.
- Operand inputs may change after acceptance without effect.
- Cout:
  - Forced 0 for Sel=00/01.
  - For subtract, Cout=1 means no borrow.
- Outputs hold their values between operations.
- Sel=10 and 11 behave identically (add/sub selected by InvertB).

Optional Feature:
- Macro SERIAL_ALU_OVERFLOW_EN.
- Defined:
  - Overflow = carry into MSB XOR carry out of MSB, for Sel=1x only; 0 for logic ops.
  - Registered with DataOut in FINISH.
- Undefined:
  - Overflow port still present, tied 0.
  - No MSB carry-in capture logic.

Decomposition:
- Package alu_serial_pkg:
  - Sel encodings SEL_AND=2'b00, SEL_OR=2'b01, SEL_ADD=2'b10.
  - FSM state enum {IDLE, RUN, FINISH}.
  - Counter width function clog2(WIDTH).
- Sub-module: one ALU_1bit instance (the datapath slice).
- Sequencer (FSM, shift registers, carry flop) lives in alu_serial_seq.

Test Plan (WIDTH=8):
- ADD: Sel=10, InvertB=0, A=0xFF, B=0x01, Start at edge 0 -> Busy cycles 1-8; Done pulse cycle 9; DataOut=0x00, Cout=1, Zero=1.
- SUB: Sel=10, InvertB=1, A=0x05, B=0x07 -> DataOut=0xFE, Cout=0, Zero=0. Repeat with A=0x07, B=0x05 -> 0x02, Cout=1.
- Logic: AND A=0xF0, B=0x3C -> 0x30, Cout=0. OR A=0xA0, B=0x05 -> 0xA5. Back-to-back Start in cycle after Done -> second op accepted.
- Handshake: Start pulsed at cycle 4 of RUN with different operands -> ignored; first result unchanged; exactly one Done.
- Reset: rst=1 at RUN cycle 3 -> next cycle Busy=0, DataOut=0, no Done. New Start then completes normally in 9 cycles.
- Overflow (macro defined): ADD 0x7F+0x01 -> DataOut=0x80, Overflow=1, Cout=0. SUB 0x80-0x01 -> 0x7F, Overflow=1. Macro undefined -> Overflow=0 on both.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: slice select encodings, sequencer states
// and the counter-width helper.
package alu_serial_pkg;

   localparam logic [1:0] SEL_AND = 2'b00;
   localparam logic [1:0] SEL_OR  = 2'b01;
   localparam logic [1:0] SEL_ADD = 2'b10;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} stateT;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/alu_serial_seq_alu1bit.sv
// One-bit ALU slice: AND / OR / full-add with optional B inversion.
// Purely combinational; no flow control.
module ALU_1bit
   import alu_serial_pkg::*;
(
   input  logic       A,
   input  logic       B,
   input  logic       Cin,
   input  logic       InvertB,
   input  logic [1:0] Sel,
   output logic       Result,
   output logic       Cout
);

   logic bEff;
   assign bEff = B ^ InvertB;

   always_comb begin
      Result = A ^ bEff ^ Cin;
      if (Sel == SEL_AND)     Result = A & bEff;
      else if (Sel == SEL_OR) Result = A | bEff;
      Cout = (A & bEff) | (A & Cin) | (bEff & Cin);
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer driving one ALU_1bit LSB-first; optional SERIAL_ALU_OVERFLOW_EN adds Overflow.
// Latency: Start edge to Done pulse is WIDTH+1 cycles; one op per WIDTH+2 cycles.
// Backpressure: Start is only taken in IDLE; requests while Busy or in FINISH are dropped.
module alu_serial_seq
   import alu_serial_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [1:0]       Sel,
   input  logic             InvertB,
   input  logic [WIDTH-1:0] DataA,
   input  logic [WIDTH-1:0] DataB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] DataOut,
   output logic             Cout,
   output logic             Zero,
   output logic             Overflow
);

   localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   stateT            state;
   logic [CW-1:0]    bitCnt;
   logic             carry;
   logic [WIDTH-1:0] aReg;
   logic [WIDTH-1:0] bReg;
   logic [WIDTH-1:0] resReg;
   logic [1:0]       selReg;
   logic             invReg;

   logic             sliceOut;
   logic             sliceCout;
   logic             lastBit;
   logic             isArith;
   logic [WIDTH-1:0] resNext;

   ALU_1bit uSlice (
      .A       (aReg[bitCnt]),
      .B       (bReg[bitCnt]),
      .Cin     (carry),
      .InvertB (invReg),
      .Sel     (selReg),
      .Result  (sliceOut),
      .Cout    (sliceCout)
   );

   assign lastBit = (bitCnt == CW'(WIDTH - 1));
   assign isArith = ((selReg & SEL_ADD) == SEL_ADD);
   // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
   assign resNext = {sliceOut, resReg[WIDTH-1:1]};

`ifdef SERIAL_ALU_OVERFLOW_EN
   logic ovReg;
   assign Overflow = ovReg;
`else
   assign Overflow = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bitCnt  <= '0;
         carry   <= 1'b0;
         aReg    <= '0;
         bReg    <= '0;
         resReg  <= '0;
         selReg  <= '0;
         invReg  <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         DataOut <= '0;
         Cout    <= 1'b0;
         Zero    <= 1'b0;
`ifdef SERIAL_ALU_OVERFLOW_EN
         ovReg   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  aReg   <= DataA;
                  bReg   <= DataB;
                  selReg <= Sel;
                  invReg <= InvertB;
                  carry  <= InvertB;
                  bitCnt <= '0;
                  Busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               carry  <= sliceCout;
               resReg <= resNext;
               if (lastBit) begin
                  Busy    <= 1'b0;
                  Done    <= 1'b1;
                  DataOut <= resNext;
                  Zero    <= (resNext == '0);
                  Cout    <= isArith & sliceCout;
`ifdef SERIAL_ALU_OVERFLOW_EN
                  // carry still holds the carry into the MSB during the last bit cycle.
                  ovReg   <= isArith & (carry ^ sliceCout);
`endif
                  state   <= FINISH;
               end else begin
                  bitCnt <= bitCnt + 1'b1;
               end
            end
            FINISH: begin
               Done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed-vector bench for alu_serial_seq at WIDTH=8; expectations are hand-computed.
module tb_alu_serial_seq;

   logic       clk;
   logic       rst;
   logic       Start;
   logic [1:0] Sel;
   logic       InvertB;
   logic [7:0] DataA;
   logic [7:0] DataB;
   logic       Busy;
   logic       Done;
   logic [7:0] DataOut;
   logic       Cout;
   logic       Zero;
   logic       Overflow;

   int checks = 0;
   int errors = 0;

   alu_serial_seq #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .Start    (Start),
      .Sel      (Sel),
      .InvertB  (InvertB),
      .DataA    (DataA),
      .DataB    (DataB),
      .Busy     (Busy),
      .Done     (Done),
      .DataOut  (DataOut),
      .Cout     (Cout),
      .Zero     (Zero),
      .Overflow (Overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op; glitch = cycle (1..9) in which a stray Start is raised, 0 for none.
   task automatic runOp(input string tag, input logic [1:0] sel, input logic inv,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expD, input logic expC, input logic expZ,
                        input logic expV, input int glitch);
      logic okBusy;
      logic expOv;
`ifdef SERIAL_ALU_OVERFLOW_EN
      expOv = expV;
`else
      expOv = 1'b0;
`endif
      Sel = sel; InvertB = inv; DataA = a; DataB = b; Start = 1'b1;
      step();
      Start = 1'b0; DataA = ~a; DataB = ~b; InvertB = ~inv;
      okBusy = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if (!(Busy === 1'b1 && Done === 1'b0)) okBusy = 1'b0;
         Start = (i == glitch);
         step();
      end
      Start = (glitch == 9);
      check({tag, "_busy_window"}, okBusy, 1);
      check({tag, "_done"}, Done, 1);
      check({tag, "_busy_fin"}, Busy, 0);
      check({tag, "_data"}, DataOut, expD);
      check({tag, "_cout"}, Cout, expC);
      check({tag, "_zero"}, Zero, expZ);
      check({tag, "_ovf"}, Overflow, expOv);
      step();
      Start = 1'b0;
      check({tag, "_done_clr"}, Done, 0);
      check({tag, "_idle_busy"}, Busy, 0);
      check({tag, "_hold"}, DataOut, expD);
   endtask

   initial begin
      logic noDone;
      rst = 1'b1; Start = 1'b0; Sel = 2'b00; InvertB = 1'b0; DataA = 8'h00; DataB = 8'h00;
      step();
      step();
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_data", DataOut, 0);
      check("rst_cout", Cout, 0);
      check("rst_zero", Zero, 0);
      check("rst_ovf", Overflow, 0);
      rst = 1'b0;
      step();

      //     tag        sel    inv   A      B      data   C     Z     V     glitch
      runOp("add_ff01", 2'b10, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 0);
      runOp("sub_5m7",  2'b10, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
      runOp("sub_7m5",  2'b10, 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0, 0);
      runOp("and",      2'b00, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0);
      runOp("or",       2'b01, 1'b0, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
      runOp("sel11",    2'b11, 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 0);
      runOp("add_c864", 2'b10, 1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, 1'b0, 0);
      runOp("hs_run",   2'b10, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 4);
      runOp("hs_fin",   2'b00, 1'b0, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 9);
      runOp("ovf_add",  2'b10, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0);
      runOp("ovf_sub",  2'b10, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 0);

      // Reset during the third RUN cycle aborts the op without a Done.
      Sel = 2'b10; InvertB = 1'b0; DataA = 8'h11; DataB = 8'h22; Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      check("abort_data", DataOut, 0);
      check("abort_zero", Zero, 0);
      noDone = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (Done !== 1'b0 || Busy !== 1'b0) noDone = 1'b0;
         step();
      end
      check("abort_quiet", noDone, 1);
      runOp("post_rst", 2'b10, 1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
